// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-ported, fixed-latency unified memory between the IF-stage
// instruction fetch and the MEM-stage data access. One access is in flight at
// a time. The data side has priority. A starvation guard hands the memory to
// fetch after STARVE_MAX back-to-back data grants that found fetch waiting.
//
// Ports
//   clk, startin                     clock (rising edge), async active-low reset
//   if_req/if_addr                   fetch request, held until if_ack
//   if_rdata/if_ack                  fetched instruction, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata    data request, held until dm_ack
//   dm_rdata/dm_ack                  load data, one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata memory issue strobe and command
//   mem_rdata                        memory read data, valid MEM_LAT cycles after mem_en
//   stall_if/stall_mem               pipeline stall lines for the two requesters
//   busy                             an access is outstanding
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              startin,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam int SC_W  = $clog2(STARVE_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(MEM_LAT - 1);
   localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);

   typedef enum logic {S_IDLE, S_BUSY} state_e;
   typedef enum logic {OWN_IF, OWN_DM} owner_e;

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SC_W-1:0]   starve_q, starve_d;
   logic              wr_q, wr_d;        // access in flight is a write
   logic [DATA_W-1:0] if_hold_q, dm_hold_q;

   logic grant_if, grant_dm, done;

   // Next-state and grant logic.
   // NOTE: every signal assigned here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;
      wr_d     = wr_q;
      grant_if = 1'b0;
      grant_dm = 1'b0;
      done     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // The grant is a combinational function of the requests, so it
            // is suppressed while reset is held to keep mem_en at zero.
            if (startin) begin
               if (if_req && starve_q == STARVE_LIM) grant_if = 1'b1;
               else if (dm_req)                      grant_dm = 1'b1;
               else if (if_req)                      grant_if = 1'b1;
            end

            if (grant_if || grant_dm) begin
               state_d = S_BUSY;
               cnt_d   = CNT_INIT;
               owner_d = grant_dm ? OWN_DM : OWN_IF;
               wr_d    = grant_dm & dm_we;
            end

            // Count data grants that left a fetch waiting; anything else
            // (fetch granted, or fetch not asking) clears the count.
            if (grant_dm && if_req)
               starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
            else
               starve_d = '0;
         end

         S_BUSY: begin
            if (cnt_q == '0) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge startin) begin
      if (!startin) begin
         state_q  <= S_IDLE;
         owner_q  <= OWN_IF;
         cnt_q    <= '0;
         starve_q <= '0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         wr_q     <= wr_d;
      end
   end

   // Read-data hold registers.
   // NOTE: these data registers are reset on purpose: the requesters may read
   // rdata before their first access and must see a defined zero.
   always_ff @(posedge clk or negedge startin) begin
      if (!startin) begin
         if_hold_q <= '0;
         dm_hold_q <= '0;
      end else begin
         if (if_ack)           if_hold_q <= mem_rdata;
         if (dm_ack && !wr_q)  dm_hold_q <= mem_rdata;
      end
   end

   // Outputs.
   assign mem_en    = grant_if | grant_dm;
   assign mem_we    = grant_dm & dm_we;
   assign mem_addr  = grant_dm ? dm_addr : (grant_if ? if_addr : '0);
   assign mem_wdata = grant_dm ? dm_wdata : '0;

   assign if_ack    = done & (owner_q == OWN_IF);
   assign dm_ack    = done & (owner_q == OWN_DM);

   // In the ack cycle the memory data is passed straight through so the
   // requester can consume it without waiting for the hold register.
   assign if_rdata  = if_ack ? mem_rdata : if_hold_q;
   assign dm_rdata  = (dm_ack && !wr_q) ? mem_rdata : dm_hold_q;

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = dm_req & ~dm_ack;
   assign busy      = (state_q == S_BUSY);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Directed bench for unified_mem_arbiter. Instance a uses MEM_LAT=2 and
// STARVE_MAX=4; instance b uses MEM_LAT=1. Inputs change 1 time unit after a
// rising edge; outputs are sampled on the falling edge. "Cycle 0" is the
// cycle in which a request is first presented.
// ---------------------------------------------------------------------------
module tb_unified_mem_arbiter;

   logic clk = 1'b0;
   logic startin;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---- instance a: MEM_LAT=2, STARVE_MAX=4 ----
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata, a_mem_rdata;
   logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata;
   logic        a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_stall_if, a_stall_mem, a_busy;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_a (
      .clk(clk), .startin(startin),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(a_dm_rdata), .dm_ack(a_dm_ack),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata),
      .stall_if(a_stall_if), .stall_mem(a_stall_mem), .busy(a_busy)
   );

   // ---- instance b: MEM_LAT=1 ----
   logic        b_if_req, b_dm_req, b_dm_we;
   logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
   logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
   logic        b_if_ack, b_dm_ack, b_mem_en, b_mem_we, b_stall_if, b_stall_mem, b_busy;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_b (
      .clk(clk), .startin(startin),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
      .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
      .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata),
      .stall_if(b_stall_if), .stall_mem(b_stall_mem), .busy(b_busy)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reset values, and no issue while reset is held even with a request up.
   task automatic test_reset();
      #2;
      checks++;
      if ({a_mem_en, a_mem_we, a_if_ack, a_dm_ack, a_busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000", {a_mem_en, a_mem_we, a_if_ack, a_dm_ack, a_busy});
      end
      checks++;
      if (a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0/0", a_mem_addr, a_mem_wdata);
      end
      checks++;
      if (a_if_rdata !== 32'h0 || a_dm_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata: got if %h dm %h expected 0/0", a_if_rdata, a_dm_rdata);
      end
      if_req  = 1'b1;
      if_addr = 32'h0000_0040;
      #1;
      checks++;
      if (a_mem_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_issue: got mem_en %b expected 0", a_mem_en);
      end
      if_req = 1'b0;
      @(negedge clk);
      startin = 1'b1;
      next_cycle();
   endtask

   // Lone fetch at MEM_LAT=2.
   task automatic test_single_fetch();
      if_req      = 1'b1;
      if_addr     = 32'h0000_0040;
      a_mem_rdata = 32'h8C01_0004;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (a_mem_en !== (c == 0) || a_mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch_mem_en c%0d: got en %b we %b expected en %b we 0", c, a_mem_en, a_mem_we, c == 0);
         end
         checks++;
         if (a_mem_addr !== ((c == 0) ? 32'h40 : 32'h0)) begin
            errors++;
            $display("FAIL fetch_mem_addr c%0d: got %h", c, a_mem_addr);
         end
         checks++;
         if (a_stall_if !== (c < 2) || a_if_ack !== (c == 2) || a_busy !== (c == 1 || c == 2)) begin
            errors++;
            $display("FAIL fetch_handshake c%0d: got stall %b ack %b busy %b expected %b %b %b",
                     c, a_stall_if, a_if_ack, a_busy, c < 2, c == 2, c == 1 || c == 2);
         end
         if (c >= 2) begin
            checks++;
            if (a_if_rdata !== 32'h8C01_0004) begin
               errors++;
               $display("FAIL fetch_rdata c%0d: got %h expected 8c010004", c, a_if_rdata);
            end
         end
         next_cycle();
         if (c == 2) begin
            if_req      = 1'b0;
            a_mem_rdata = 32'h0;
         end
      end
   endtask

   // Simultaneous requests: data write first, then the fetch.
   task automatic test_dm_priority();
      if_req      = 1'b1;  if_addr = 32'h0000_0044;
      dm_req      = 1'b1;  dm_we   = 1'b1;
      dm_addr     = 32'h0000_0100;  dm_wdata = 32'hDEAD_BEEF;
      a_mem_rdata = 32'h1111_2222;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         checks++;
         if (a_mem_en !== (c == 0 || c == 3) || a_mem_we !== (c == 0)) begin
            errors++;
            $display("FAIL prio_en_we c%0d: got en %b we %b", c, a_mem_en, a_mem_we);
         end
         checks++;
         if (a_mem_addr !== ((c == 0) ? 32'h100 : (c == 3) ? 32'h44 : 32'h0) ||
             a_mem_wdata !== ((c == 0) ? 32'hDEAD_BEEF : 32'h0)) begin
            errors++;
            $display("FAIL prio_addr c%0d: got addr %h wdata %h", c, a_mem_addr, a_mem_wdata);
         end
         checks++;
         if (a_dm_ack !== (c == 2) || a_if_ack !== (c == 5) ||
             a_stall_mem !== (c < 2) || a_stall_if !== (c < 5)) begin
            errors++;
            $display("FAIL prio_acks c%0d: got dm_ack %b if_ack %b stall_mem %b stall_if %b",
                     c, a_dm_ack, a_if_ack, a_stall_mem, a_stall_if);
         end
         checks++;
         if (a_dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL prio_dm_rdata_after_write c%0d: got %h expected 0", c, a_dm_rdata);
         end
         if (c == 5) begin
            checks++;
            if (a_if_rdata !== 32'h1111_2222) begin
               errors++;
               $display("FAIL prio_if_rdata: got %h expected 11112222", a_if_rdata);
            end
         end
         next_cycle();
         if (c == 2) begin dm_req = 1'b0; dm_we = 1'b0; end
         if (c == 5) if_req = 1'b0;
      end
   endtask

   // Both held high: DM,DM,DM,DM,IF,DM with a grant every 3 cycles.
   task automatic test_starvation();
      if_req      = 1'b1;  if_addr = 32'h0000_0080;
      dm_req      = 1'b1;  dm_we   = 1'b0;  dm_addr = 32'h0000_0300;
      a_mem_rdata = 32'h3333_0000;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         checks++;
         if (a_mem_en !== (c % 3 == 0)) begin
            errors++;
            $display("FAIL starve_en c%0d: got %b expected %b", c, a_mem_en, c % 3 == 0);
         end
         if (c % 3 == 0) begin
            checks++;
            if (a_mem_addr !== ((c == 12) ? 32'h80 : 32'h300)) begin
               errors++;
               $display("FAIL starve_grant c%0d: got addr %h expected %h", c, a_mem_addr,
                        (c == 12) ? 32'h80 : 32'h300);
            end
         end
         checks++;
         if (a_if_ack !== (c == 14)) begin
            errors++;
            $display("FAIL starve_if_ack c%0d: got %b expected %b", c, a_if_ack, c == 14);
         end
         next_cycle();
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      next_cycle();
   endtask

   // Reset pulse in cycle 1 of a data read, then a normal fetch.
   task automatic test_reset_mid_busy();
      logic saw_bad;
      dm_req = 1'b1;  dm_we = 1'b0;  dm_addr = 32'h0000_0500;
      a_mem_rdata = 32'h5555_0000;
      @(negedge clk);
      checks++;
      if (a_mem_en !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_grant: got mem_en %b expected 1", a_mem_en);
      end
      next_cycle();
      startin = 1'b0;
      #1;
      checks++;
      if ({a_mem_en, a_dm_ack, a_busy} !== 3'b000 || a_if_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got en/ack/busy %b if_rdata %h expected 000/0",
                  {a_mem_en, a_dm_ack, a_busy}, a_if_rdata);
      end
      dm_req = 1'b0;
      @(negedge clk);
      startin = 1'b1;
      saw_bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (a_dm_ack !== 1'b0 || a_busy !== 1'b0) saw_bad = 1'b1;
      end
      checks++;
      if (saw_bad !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_no_late_ack: got ack/busy activity after reset, expected none");
      end
      next_cycle();
      if_req = 1'b1;  if_addr = 32'h0000_0060;  a_mem_rdata = 32'h0000_6060;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (a_mem_en !== (c == 0) || a_if_ack !== (c == 2)) begin
            errors++;
            $display("FAIL rst_mid_refetch c%0d: got en %b ack %b expected %b %b",
                     c, a_mem_en, a_if_ack, c == 0, c == 2);
         end
         next_cycle();
      end
      if_req = 1'b0;
   endtask

   // MEM_LAT=1 back-to-back reads.
   task automatic test_back_to_back();
      b_dm_req = 1'b1;  b_dm_we = 1'b0;  b_dm_addr = 32'h0000_0200;
      b_mem_rdata = 32'hB000_0200;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (b_mem_en !== (c == 0 || c == 2) || b_dm_ack !== (c == 1 || c == 3) ||
             b_busy !== (c == 1 || c == 3)) begin
            errors++;
            $display("FAIL b2b_timing c%0d: got en %b ack %b busy %b", c, b_mem_en, b_dm_ack, b_busy);
         end
         if (c == 0 || c == 2) begin
            checks++;
            if (b_mem_addr !== ((c == 0) ? 32'h200 : 32'h204)) begin
               errors++;
               $display("FAIL b2b_addr c%0d: got %h", c, b_mem_addr);
            end
         end
         if (c == 1 || c == 3) begin
            checks++;
            if (b_dm_rdata !== ((c == 1) ? 32'hB000_0200 : 32'hB000_0204)) begin
               errors++;
               $display("FAIL b2b_rdata c%0d: got %h", c, b_dm_rdata);
            end
         end
         next_cycle();
         if (c == 1) begin b_dm_addr = 32'h0000_0204; b_mem_rdata = 32'hB000_0204; end
         if (c == 3) b_dm_req = 1'b0;
      end
   endtask

   // Per-requester hold registers; writes leave dm_rdata alone.
   task automatic test_rdata_hold();
      if_req = 1'b1;  if_addr = 32'h0000_0090;  a_mem_rdata = 32'hAAAA_5555;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 2) begin
            checks++;
            if (a_if_ack !== 1'b1) begin
               errors++;
               $display("FAIL hold_if_ack: got %b expected 1", a_if_ack);
            end
         end
         next_cycle();
      end
      if_req = 1'b0;
      dm_req = 1'b1;  dm_we = 1'b0;  dm_addr = 32'h0000_0310;  a_mem_rdata = 32'h1234_5678;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 2) begin
            checks++;
            if (a_dm_ack !== 1'b1 || a_dm_rdata !== 32'h1234_5678) begin
               errors++;
               $display("FAIL hold_dm_read: got ack %b rdata %h expected 1 12345678", a_dm_ack, a_dm_rdata);
            end
         end
         next_cycle();
      end
      dm_we = 1'b1;  dm_addr = 32'h0000_0314;  dm_wdata = 32'h0BAD_F00D;  a_mem_rdata = 32'hFFFF_FFFF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 2) begin
            checks++;
            if (a_dm_ack !== 1'b1 || a_dm_rdata !== 32'h1234_5678) begin
               errors++;
               $display("FAIL hold_dm_write: got ack %b rdata %h expected 1 12345678", a_dm_ack, a_dm_rdata);
            end
         end
         next_cycle();
      end
      dm_req = 1'b0;  dm_we = 1'b0;
      @(negedge clk);
      checks++;
      if (a_dm_rdata !== 32'h1234_5678 || a_if_rdata !== 32'hAAAA_5555) begin
         errors++;
         $display("FAIL hold_final: got dm %h if %h expected 12345678 aaaa5555", a_dm_rdata, a_if_rdata);
      end
   endtask

   initial begin
      startin  = 1'b0;
      if_req   = 1'b0;  if_addr  = '0;
      dm_req   = 1'b0;  dm_we    = 1'b0;  dm_addr = '0;  dm_wdata = '0;
      a_mem_rdata = '0;
      b_if_req = 1'b0;  b_if_addr = '0;
      b_dm_req = 1'b0;  b_dm_we   = 1'b0;  b_dm_addr = '0;  b_dm_wdata = '0;
      b_mem_rdata = '0;

      test_reset();
      test_single_fetch();
      test_dm_priority();
      test_starvation();
      test_reset_mid_busy();
      test_back_to_back();
      test_rdata_hold();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
